// File: rtl/mem_access_sched.sv
// rtl/mem_access_sched.sv - single-port memory access scheduler for fetch, load/store and TRAP vector reads
module mem_access_sched #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_fetch,
  input  logic       req_data,
  input  logic       req_trap,
  input  logic       data_we,
  input  logic       mem_ready,
  output logic [2:0] grant,
  output logic [2:0] done,
  output logic       marmux_sel,
  output logic       ld_mar,
  output logic       mem_en,
  output logic       mem_we,
  output logic       ld_mdr,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADDR   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Last ACCESS cycle index before the access is abandoned.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] OWN_FETCH = 3'b001;
  localparam logic [2:0] OWN_DATA  = 3'b010;
  localparam logic [2:0] OWN_TRAP  = 3'b100;

  state_t           state_q, state_d;
  logic [2:0]       owner_q, owner_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;

  logic [2:0]       grant_q, grant_d;
  logic [2:0]       done_q, done_d;
  logic             marmux_sel_q, marmux_sel_d;
  logic             ld_mar_q, ld_mar_d;
  logic             mem_en_q, mem_en_d;
  logic             mem_we_q, mem_we_d;
  logic             busy_q, busy_d;
  logic             timeout_err_q, timeout_err_d;

  // Next-state, owner latch, wait counter and abort flag.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        abort_d = 1'b0;
        if (req_trap) begin
          owner_d = OWN_TRAP;
          we_d    = 1'b0;
          state_d = S_ADDR;
        end else if (req_data) begin
          owner_d = OWN_DATA;
          we_d    = data_we;
          state_d = S_ADDR;
        end else if (req_fetch) begin
          owner_d = OWN_FETCH;
          we_d    = 1'b0;
          state_d = S_ADDR;
        end else begin
          owner_d = '0;
          we_d    = 1'b0;
        end
      end
      S_ADDR: begin
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (mem_ready) begin
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          abort_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        abort_d = 1'b0;
        owner_d = '0;
        we_d    = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        owner_d = '0;
        we_d    = 1'b0;
        cnt_d   = '0;
        abort_d = 1'b0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in the state they describe.
  always_comb begin
    grant_d       = (state_d != S_IDLE) ? owner_d : 3'b000;
    done_d        = (state_d == S_DONE) ? owner_d : 3'b000;
    marmux_sel_d  = !((state_d != S_IDLE) && owner_d[2]);
    ld_mar_d      = (state_d == S_ADDR);
    mem_en_d      = (state_d == S_ACCESS);
    mem_we_d      = (state_d == S_ACCESS) && we_d;
    busy_d        = (state_d != S_IDLE);
    timeout_err_d = (state_d == S_DONE) && abort_d;
  end

  // All scheduler state and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      owner_q       <= '0;
      we_q          <= 1'b0;
      cnt_q         <= '0;
      abort_q       <= 1'b0;
      grant_q       <= 3'b000;
      done_q        <= 3'b000;
      marmux_sel_q  <= 1'b1;
      ld_mar_q      <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      we_q          <= we_d;
      cnt_q         <= cnt_d;
      abort_q       <= abort_d;
      grant_q       <= grant_d;
      done_q        <= done_d;
      marmux_sel_q  <= marmux_sel_d;
      ld_mar_q      <= ld_mar_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign marmux_sel  = marmux_sel_q;
  assign ld_mar      = ld_mar_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  // MDR captures read data in the same cycle memory signals ready; never on writes.
  assign ld_mdr      = (state_q == S_ACCESS) && mem_ready && !we_q;

endmodule

// File: tb/tb_mem_access_sched.sv
// tb/tb_mem_access_sched.sv - directed self-checking bench for mem_access_sched
module tb_mem_access_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_fetch, req_data, req_trap, data_we, mem_ready;
  logic [2:0] grant, done;
  logic       marmux_sel, ld_mar, mem_en, mem_we, ld_mdr, busy, timeout_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // {grant, done, marmux_sel, ld_mar, mem_en, mem_we, ld_mdr, busy, timeout_err}
  logic [12:0] obs;
  logic [12:0] exp_v;
  assign obs = {grant, done, marmux_sel, ld_mar, mem_en, mem_we, ld_mdr, busy, timeout_err};

  // Small MAR model fed by the scheduler's mux select and load strobe.
  logic [7:0]  ir      = 8'h25;
  logic [15:0] dp_addr = 16'h3000;
  logic [15:0] mar     = 16'h0000;
  always @(posedge clk) if (ld_mar) mar <= marmux_sel ? dp_addr : {8'h00, ir};

  mem_access_sched #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_fetch(req_fetch), .req_data(req_data), .req_trap(req_trap),
    .data_we(data_we), .mem_ready(mem_ready),
    .grant(grant), .done(done), .marmux_sel(marmux_sel), .ld_mar(ld_mar),
    .mem_en(mem_en), .mem_we(mem_we), .ld_mdr(ld_mdr), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_fetch = 0; req_data = 0; req_trap = 0; data_we = 0; mem_ready = 0;
    tick(); tick();
    #1;
    exp_v = 13'b000_000_1_0_0_0_0_0_0;
    total_cnt++;
    if (obs !== exp_v) $display("FAIL reset_state got=%b exp=%b", obs, exp_v); else pass_cnt++;
    rst = 1'b0;
    tick(); #1;
    total_cnt++;
    if (obs !== exp_v) $display("FAIL idle_no_req got=%b exp=%b", obs, exp_v); else pass_cnt++;
  endtask

  task automatic test_fetch();
    req_fetch = 1; mem_ready = 1;   // ready outside ACCESS must be ignored
    tick(); #1;
    exp_v = 13'b001_000_1_1_0_0_0_1_0;
    total_cnt++;
    if (obs !== exp_v) $display("FAIL fetch_addr got=%b exp=%b", obs, exp_v); else pass_cnt++;
    tick(); #1;
    exp_v = 13'b001_000_1_0_1_0_1_1_0;
    total_cnt++;
    if (obs !== exp_v) $display("FAIL fetch_access got=%b exp=%b", obs, exp_v); else pass_cnt++;
    tick(); req_fetch = 0; mem_ready = 0; #1;
    exp_v = 13'b001_001_1_0_0_0_0_1_0;
    total_cnt++;
    if (obs !== exp_v) $display("FAIL fetch_done got=%b exp=%b", obs, exp_v); else pass_cnt++;
    total_cnt++;
    if (mar !== 16'h3000) $display("FAIL fetch_mar got=%h exp=%h", mar, 16'h3000); else pass_cnt++;
    tick(); #1;
    exp_v = 13'b000_000_1_0_0_0_0_0_0;
    total_cnt++;
    if (obs !== exp_v) $display("FAIL fetch_idle got=%b exp=%b", obs, exp_v); else pass_cnt++;
  endtask

  task automatic test_trap();
    req_trap = 1;
    tick(); #1;
    exp_v = 13'b100_000_0_1_0_0_0_1_0;
    total_cnt++;
    if (obs !== exp_v) $display("FAIL trap_addr got=%b exp=%b", obs, exp_v); else pass_cnt++;
    tick(); mem_ready = 1; #1;
    exp_v = 13'b100_000_0_0_1_0_1_1_0;
    total_cnt++;
    if (obs !== exp_v) $display("FAIL trap_access got=%b exp=%b", obs, exp_v); else pass_cnt++;
    total_cnt++;
    if (mar !== 16'h0025) $display("FAIL trap_mar got=%h exp=%h", mar, 16'h0025); else pass_cnt++;
    tick(); req_trap = 0; mem_ready = 0; #1;
    total_cnt++;
    if ({grant, done, timeout_err} !== 7'b100_100_0)
      $display("FAIL trap_done got=%b exp=%b", {grant, done, timeout_err}, 7'b100_100_0);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [2:0] seen [3];
    int         at   [3];
    int         n = 0;
    req_fetch = 1; req_data = 1; req_trap = 1; data_we = 0; mem_ready = 1;
    for (int c = 0; c < 40 && n < 3; c++) begin
      tick(); #1;
      if (done != 3'b000) begin
        seen[n] = done;
        at[n]   = c;
        n++;
        if (done[2]) req_trap = 0;
        if (done[1]) req_data = 0;
        if (done[0]) req_fetch = 0;
      end
    end
    req_fetch = 0; req_data = 0; req_trap = 0; mem_ready = 0;
    total_cnt++;
    if (n !== 3) $display("FAIL b2b_pulse_count got=%0d exp=3", n);
    else begin
      pass_cnt++;
      total_cnt++;
      if ({seen[0], seen[1], seen[2]} !== 9'b100_010_001)
        $display("FAIL b2b_order got=%b exp=%b", {seen[0], seen[1], seen[2]}, 9'b100_010_001);
      else pass_cnt++;
      total_cnt++;
      if ((at[1] - at[0]) !== 4 || (at[2] - at[1]) !== 4)
        $display("FAIL b2b_spacing got=%0d,%0d exp=4,4", at[1] - at[0], at[2] - at[1]);
      else pass_cnt++;
    end
    tick(); tick();
  endtask

  task automatic test_store_wait();
    req_data = 1; data_we = 1;
    tick(); data_we = 0; #1;   // change after grant must be ignored
    exp_v = 13'b010_000_1_1_0_0_0_1_0;
    total_cnt++;
    if (obs !== exp_v) $display("FAIL store_addr got=%b exp=%b", obs, exp_v); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      tick(); mem_ready = (i == 3); #1;
      exp_v = 13'b010_000_1_0_1_1_0_1_0;
      total_cnt++;
      if (obs !== exp_v) $display("FAIL store_access%0d got=%b exp=%b", i, obs, exp_v); else pass_cnt++;
    end
    tick(); req_data = 0; mem_ready = 0; #1;
    exp_v = 13'b010_010_1_0_0_0_0_1_0;
    total_cnt++;
    if (obs !== exp_v) $display("FAIL store_done got=%b exp=%b", obs, exp_v); else pass_cnt++;
    tick();
  endtask

  task automatic test_timeout();
    int en_cycles = 0;
    int mdr_hits  = 0;
    int got_done  = 0;
    req_fetch = 1; mem_ready = 0;
    for (int c = 0; c < 40 && got_done == 0; c++) begin
      tick(); #1;
      if (mem_en) en_cycles++;
      if (ld_mdr) mdr_hits++;
      if (done != 3'b000) begin
        got_done = 1;
        req_fetch = 0;
        exp_v = 13'b001_001_1_0_0_0_0_1_1;
        total_cnt++;
        if (obs !== exp_v) $display("FAIL timeout_done got=%b exp=%b", obs, exp_v); else pass_cnt++;
      end
    end
    total_cnt++;
    if (got_done !== 1) $display("FAIL timeout_no_done got=%0d exp=1", got_done); else pass_cnt++;
    total_cnt++;
    if (en_cycles !== 16) $display("FAIL timeout_en_cycles got=%0d exp=16", en_cycles); else pass_cnt++;
    total_cnt++;
    if (mdr_hits !== 0) $display("FAIL timeout_ld_mdr got=%0d exp=0", mdr_hits); else pass_cnt++;
    req_fetch = 0;
    tick(); #1;
    total_cnt++;
    if ({busy, timeout_err} !== 2'b00) $display("FAIL timeout_clear got=%b exp=00", {busy, timeout_err}); else pass_cnt++;
  endtask

  task automatic test_reset_mid_access();
    req_fetch = 1; mem_ready = 0;
    tick(); tick();
    rst = 1; #1;
    total_cnt++;
    if (mem_en !== 1'b1) $display("FAIL rst_pre_access got=%b exp=1", mem_en); else pass_cnt++;
    tick(); rst = 0; #1;
    exp_v = 13'b000_000_1_0_0_0_0_0_0;
    total_cnt++;
    if (obs !== exp_v) $display("FAIL rst_abort got=%b exp=%b", obs, exp_v); else pass_cnt++;
    tick(); #1;
    exp_v = 13'b001_000_1_1_0_0_0_1_0;
    total_cnt++;
    if (obs !== exp_v) $display("FAIL rst_regrant got=%b exp=%b", obs, exp_v); else pass_cnt++;
    tick(); mem_ready = 1; #1;
    tick(); req_fetch = 0; mem_ready = 0; #1;
    total_cnt++;
    if (done !== 3'b001) $display("FAIL rst_regrant_done got=%b exp=001", done); else pass_cnt++;
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_trap();
    test_back_to_back();
    test_store_wait();
    test_timeout();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
